// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Purpose : Cache-side and memory-side bus bundle of the memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_read_request;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_response;
   logic [DATA_WIDTH-1:0] i_read_data;

   logic                  d_read_request;
   logic                  d_write_request;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_write_data;
   logic                  d_response;
   logic [DATA_WIDTH-1:0] d_read_data;

   logic                  memory_read_request;
   logic                  memory_write_request;
   logic                  memory_response;
   logic [ADDR_WIDTH-1:0] memory_addr;
   logic [DATA_WIDTH-1:0] memory_write_data;
   logic [DATA_WIDTH-1:0] memory_read_data;

   // Arbiter view
   modport slave (
      input  i_read_request, i_addr,
      input  d_read_request, d_write_request, d_addr, d_write_data,
      input  memory_response, memory_read_data,
      output i_response, i_read_data, d_response, d_read_data,
      output memory_read_request, memory_write_request,
      output memory_addr, memory_write_data
   );

   // Environment view: caches and memory controller
   modport master (
      output i_read_request, i_addr,
      output d_read_request, d_write_request, d_addr, d_write_data,
      output memory_response, memory_read_data,
      input  i_response, i_read_data, d_response, d_read_data,
      input  memory_read_request, memory_write_request,
      input  memory_addr, memory_write_data
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one memory port between I-cache (read) and D-cache
//           (read/write) miss paths, with a post-response holdoff.
//           Optional macro MEM_ARBITER_ROUND_ROBIN_EN: alternate on contention.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int HOLDOFF_CYCLES = 1
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   mem_arbiter_if.slave bus
);

   localparam int CNT_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY_I  = 2'd1;
   localparam logic [1:0] ST_BUSY_D  = 2'd2;
   localparam logic [1:0] ST_HOLDOFF = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [CNT_W-1:0]      r_hold_cnt;
   logic [CNT_W-1:0]      w_next_hold_cnt;
   logic                  r_last_owner_d;
   logic                  r_mem_rd;
   logic                  r_mem_wr;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   logic                  w_d_req;
   logic                  w_prefer_d;
   logic                  w_grant_d;
   logic                  w_grant_i;
   logic                  w_busy_done;

   assign w_d_req = bus.d_read_request | bus.d_write_request;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   assign w_prefer_d = ~r_last_owner_d;
`else
   // Fixed priority: D always preferred; last_owner is kept for visibility only.
   assign w_prefer_d = 1'b1 | r_last_owner_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_hold_cnt     <= '0;
         r_last_owner_d <= 1'b0;
         r_mem_rd       <= 1'b0;
         r_mem_wr       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
      end else begin
         r_state    <= w_next_state;
         r_hold_cnt <= w_next_hold_cnt;
         if (w_grant_d) begin
            r_last_owner_d <= 1'b1;
            r_mem_addr     <= bus.d_addr;
            r_mem_wdata    <= bus.d_write_data;
            // A simultaneous read+write issues the write; the read stays pending.
            r_mem_wr       <= bus.d_write_request;
            r_mem_rd       <= ~bus.d_write_request;
         end else if (w_grant_i) begin
            r_last_owner_d <= 1'b0;
            r_mem_addr     <= bus.i_addr;
            r_mem_wdata    <= '0;
            r_mem_wr       <= 1'b0;
            r_mem_rd       <= 1'b1;
         end else if (w_busy_done) begin
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
         end
      end
   end

   // Next-state and arbitration
   always_comb begin
      w_next_state    = r_state;
      w_next_hold_cnt = r_hold_cnt;
      w_grant_d       = 1'b0;
      w_grant_i       = 1'b0;
      w_busy_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_d_req && (w_prefer_d || !bus.i_read_request)) begin
               w_grant_d    = 1'b1;
               w_next_state = ST_BUSY_D;
            end else if (bus.i_read_request) begin
               w_grant_i    = 1'b1;
               w_next_state = ST_BUSY_I;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (bus.memory_response) begin
               w_busy_done     = 1'b1;
               w_next_state    = ST_HOLDOFF;
               w_next_hold_cnt = HOLD_LOAD;
            end
         end
         ST_HOLDOFF: begin
            if (r_hold_cnt <= HOLD_LAST) begin
               w_next_state    = ST_IDLE;
               w_next_hold_cnt = '0;
            end else begin
               w_next_hold_cnt = r_hold_cnt - HOLD_LAST;
            end
         end
         default: begin
            w_next_state    = ST_IDLE;
            w_next_hold_cnt = '0;
         end
      endcase
   end

   // Outputs: response routed to the owner only; read data is a pass-through
   always_comb begin
      bus.i_response           = (r_state == ST_BUSY_I) && bus.memory_response;
      bus.d_response           = (r_state == ST_BUSY_D) && bus.memory_response;
      bus.i_read_data          = bus.memory_read_data;
      bus.d_read_data          = bus.memory_read_data;
      bus.memory_read_request  = r_mem_rd;
      bus.memory_write_request = r_mem_wr;
      bus.memory_addr          = r_mem_addr;
      bus.memory_write_data    = r_mem_wdata;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Directed scoreboard bench for mem_arbiter (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int HOLD = 1;

   typedef struct packed {
      logic          is_d;
      logic          is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   txn_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .HOLDOFF_CYCLES(HOLD)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200us");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic is_d, input logic is_wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      txn_t t;
      t.is_d  = is_d;
      t.is_wr = is_wr;
      t.addr  = addr;
      t.wdata = wdata;
      sb.push_back(t);
   endtask

   // Waits for a memory command, pops the expected transaction and checks it.
   task automatic grab(output int waited, output txn_t e, output bit ok);
      waited = 0;
      ok     = 1'b0;
      e      = '0;
      smp();
      while (!(bus.memory_read_request || bus.memory_write_request) && waited < 20) begin
         cyc();
         smp();
         waited++;
      end
      chk("grant_seen", 32'(bus.memory_read_request | bus.memory_write_request), 32'd1);
      if (!(bus.memory_read_request || bus.memory_write_request)) return;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("grant_rd",    32'(bus.memory_read_request),  32'(!e.is_wr));
      chk("grant_wr",    32'(bus.memory_write_request), 32'(e.is_wr));
      chk("grant_addr",  bus.memory_addr,               e.addr);
      chk("grant_wdata", bus.memory_write_data,         e.wdata);
      ok = 1'b1;
   endtask

   task automatic drop(input txn_t e);
      if (!e.is_d)      bus.i_read_request  = 1'b0;
      else if (e.is_wr) bus.d_write_request = 1'b0;
      else              bus.d_read_request  = 1'b0;
   endtask

   // Full transaction; returns at the start of the second cycle after the response.
   task automatic serve(input int delay, input logic [DW-1:0] rdata,
                        input bit perturb, input bit hold, output int waited);
      txn_t e;
      bit ok;
      logic [AW-1:0] save_d;
      logic [AW-1:0] save_i;
      grab(waited, e, ok);
      if (!ok) return;
      save_d = bus.d_addr;
      save_i = bus.i_addr;
      for (int k = 1; k < delay; k++) begin
         cyc();
         if (perturb) begin
            bus.d_addr = ~save_d;
            bus.i_addr = ~save_i;
         end
         smp();
         chk("busy_addr", bus.memory_addr, e.addr);
         chk("busy_resp", 32'({bus.i_response, bus.d_response}), 32'd0);
      end
      cyc();
      bus.memory_response  = 1'b1;
      bus.memory_read_data = rdata;
      smp();
      chk("resp_i", 32'(bus.i_response), 32'(!e.is_d));
      chk("resp_d", 32'(bus.d_response), 32'(e.is_d));
      chk("rdata", e.is_d ? bus.d_read_data : bus.i_read_data, rdata);
      cyc();
      bus.memory_response  = 1'b0;
      bus.memory_read_data = '0;
      bus.d_addr = save_d;
      bus.i_addr = save_i;
      if (!hold) drop(e);
      smp();
      chk("post_req",  32'({bus.memory_read_request, bus.memory_write_request}), 32'd0);
      chk("post_resp", 32'({bus.i_response, bus.d_response}), 32'd0);
      cyc();
   endtask

   initial begin
      int   w;
      txn_t e;
      bit   ok;

      bus.i_read_request   = 1'b0;
      bus.i_addr           = '0;
      bus.d_read_request   = 1'b0;
      bus.d_write_request  = 1'b0;
      bus.d_addr           = '0;
      bus.d_write_data     = '0;
      bus.memory_response  = 1'b0;
      bus.memory_read_data = '0;

      // Reset state
      cyc();
      cyc();
      smp();
      chk("rst_rd",    32'(bus.memory_read_request),  32'd0);
      chk("rst_wr",    32'(bus.memory_write_request), 32'd0);
      chk("rst_addr",  bus.memory_addr,               32'd0);
      chk("rst_wdata", bus.memory_write_data,         32'd0);
      chk("rst_resp",  32'({bus.i_response, bus.d_response}), 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Single I read, response three cycles after grant
      bus.i_addr         = 32'h0000_0100;
      bus.i_read_request = 1'b1;
      push(1'b0, 1'b0, 32'h0000_0100, 32'h0);
      serve(3, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
      chk("i_latency", 32'(w), 32'd1);

      // D write with address/data changing while busy
      bus.d_addr          = 32'h2000_0004;
      bus.d_write_data    = 32'h1234_5678;
      bus.d_write_request = 1'b1;
      push(1'b1, 1'b1, 32'h2000_0004, 32'h1234_5678);
      serve(3, 32'hA5A5_A5A5, 1'b1, 1'b0, w);
      chk("d_latency", 32'(w), 32'd1);

      // Holdoff: request still high in IDLE is served again
      bus.i_addr         = 32'h0000_0300;
      bus.i_read_request = 1'b1;
      push(1'b0, 1'b0, 32'h0000_0300, 32'h0);
      serve(1, 32'h0000_0301, 1'b0, 1'b1, w);
      push(1'b0, 1'b0, 32'h0000_0300, 32'h0);
      serve(2, 32'h0000_0302, 1'b0, 1'b1, w);
      chk("regrant_latency", 32'(w), 32'(HOLD));
      // Holdoff: request dropped one cycle after response is not re-served
      bus.i_read_request = 1'b0;
      smp();
      chk("no_regrant_a", 32'({bus.memory_read_request, bus.memory_write_request}), 32'd0);
      cyc();
      smp();
      chk("no_regrant_b", 32'({bus.memory_read_request, bus.memory_write_request}), 32'd0);
      cyc();

      // Stray memory response in IDLE
      bus.memory_response  = 1'b1;
      bus.memory_read_data = 32'h5555_5555;
      smp();
      chk("stray_resp", 32'({bus.i_response, bus.d_response}), 32'd0);
      chk("stray_req",  32'({bus.memory_read_request, bus.memory_write_request}), 32'd0);
      cyc();
      bus.memory_response  = 1'b0;
      bus.memory_read_data = '0;
      bus.i_addr           = 32'h0000_0400;
      bus.i_read_request   = 1'b1;
      push(1'b0, 1'b0, 32'h0000_0400, 32'h0);
      serve(2, 32'h0000_0401, 1'b0, 1'b0, w);
      chk("stray_then_latency", 32'(w), 32'd1);

      // D read and write together: write first, read stays pending
      bus.d_addr          = 32'h0000_0500;
      bus.d_write_data    = 32'h0000_0077;
      bus.d_write_request = 1'b1;
      bus.d_read_request  = 1'b1;
      push(1'b1, 1'b1, 32'h0000_0500, 32'h0000_0077);
      push(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0077);
      serve(1, 32'h0000_0501, 1'b0, 1'b0, w);
      chk("rw_write_latency", 32'(w), 32'd1);
      serve(2, 32'h0000_0502, 1'b0, 1'b0, w);
      chk("rw_read_latency", 32'(w), 32'(HOLD));

      // Reset in the middle of an I read
      bus.i_addr         = 32'h0000_0600;
      bus.i_read_request = 1'b1;
      push(1'b0, 1'b0, 32'h0000_0600, 32'h0);
      grab(w, e, ok);
      cyc();
      rst_n              = 1'b0;
      bus.i_read_request = 1'b0;
      smp();
      cyc();
      rst_n = 1'b1;
      smp();
      chk("abort_rd",   32'(bus.memory_read_request), 32'd0);
      chk("abort_resp", 32'({bus.i_response, bus.d_response}), 32'd0);
      cyc();
      bus.memory_response = 1'b1;
      smp();
      chk("abort_late_resp", 32'({bus.i_response, bus.d_response}), 32'd0);
      cyc();
      bus.memory_response = 1'b0;

      // First contention after reset goes to D in both modes
      bus.i_addr         = 32'h0000_0700;
      bus.d_addr         = 32'h0000_0800;
      bus.d_write_data   = 32'h0000_0099;
      bus.i_read_request = 1'b1;
      bus.d_read_request = 1'b1;
      push(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0099);
      push(1'b0, 1'b0, 32'h0000_0700, 32'h0);
      serve(2, 32'h0000_0801, 1'b0, 1'b0, w);
      chk("c1_first_latency", 32'(w), 32'd1);
      serve(2, 32'h0000_0701, 1'b0, 1'b0, w);
      chk("c1_second_latency", 32'(w), 32'(HOLD));

      // Lone D write makes D the last owner
      bus.d_addr          = 32'h0000_0900;
      bus.d_write_data    = 32'h0000_00AB;
      bus.d_write_request = 1'b1;
      push(1'b1, 1'b1, 32'h0000_0900, 32'h0000_00AB);
      serve(1, 32'h0000_0901, 1'b0, 1'b0, w);

      // Second contention: round robin picks I, fixed priority picks D
      bus.i_addr         = 32'h0000_0A00;
      bus.d_addr         = 32'h0000_0B00;
      bus.d_write_data   = 32'h0000_00CD;
      bus.i_read_request = 1'b1;
      bus.d_read_request = 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      push(1'b0, 1'b0, 32'h0000_0A00, 32'h0);
      push(1'b1, 1'b0, 32'h0000_0B00, 32'h0000_00CD);
`else
      push(1'b1, 1'b0, 32'h0000_0B00, 32'h0000_00CD);
      push(1'b0, 1'b0, 32'h0000_0A00, 32'h0);
`endif
      serve(2, 32'h0000_0C01, 1'b0, 1'b0, w);
      chk("c2_first_latency", 32'(w), 32'd1);
      serve(1, 32'h0000_0C02, 1'b0, 1'b0, w);
      chk("c2_second_latency", 32'(w), 32'(HOLD));

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
